// File: rtl/cve2_hwloop_pkg.sv
// Shared constants for the hardware-loop unit: write-enable bit positions,
// readback field encoding and the supported loop-count bound.
package cve2_hwloop_pkg;

  localparam int unsigned WE_START  = 0;
  localparam int unsigned WE_END    = 1;
  localparam int unsigned WE_CNT    = 2;
  localparam int unsigned MAX_LOOPS = 8;

  typedef enum logic [1:0] {
    RD_START = 2'd0,
    RD_END   = 2'd1,
    RD_COUNT = 2'd2,
    RD_RSVD  = 2'd3
  } rd_field_e;

endpackage

// File: rtl/cve2_hwloop_entry.sv
// One hardware loop: start/end address and iteration counter, plus the
// end-of-body match against the retiring PC.
module cve2_hwloop_entry
  import cve2_hwloop_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 we_start_i,
  input  logic                 we_end_i,
  input  logic                 we_cnt_i,
  input  logic                 dec_i,
  input  logic [31:0]          start_data_i,
  input  logic [31:0]          end_data_i,
  input  logic [CNT_WIDTH-1:0] cnt_data_i,
  input  logic [31:0]          pc_i,
  output logic [31:0]          start_q,
  output logic [31:0]          end_q,
  output logic [CNT_WIDTH-1:0] cnt_q,
  output logic                 match
);

  assign match = valid_i && (cnt_q != '0) && (pc_i == end_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (we_start_i) start_q <= {start_data_i[31:2], 2'b00};
      if (we_end_i)   end_q   <= {end_data_i[31:2], 2'b00};
      // A count write overrides the decrement of the retiring iteration.
      if (we_cnt_i)                      cnt_q <= cnt_data_i;
      else if (dec_i && cnt_q != '0)     cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/cve2_hwloop_unit.sv
// Hardware-loop unit: N_LOOPS entries, innermost-first priority select and,
// when CVE2_HWLOOP_READBACK_EN is defined, a registered readback port.
module cve2_hwloop_unit
  import cve2_hwloop_pkg::*;
#(
  parameter int N_LOOPS    = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int LOOP_IDX_W = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [2:0]            we_i,
  input  logic [LOOP_IDX_W-1:0] regid_i,
  input  logic [31:0]           start_data_i,
  input  logic [31:0]           end_data_i,
  input  logic [CNT_WIDTH-1:0]  cnt_data_i,
  input  logic [31:0]           pc_i,
  output logic                  jump_o,
  output logic [31:0]           jump_target_o,
  output logic [N_LOOPS-1:0]    loop_active_o,
  output logic                  exit_o
`ifdef CVE2_HWLOOP_READBACK_EN
  ,
  input  logic                  rd_en_i,
  input  logic [LOOP_IDX_W-1:0] rd_regid_i,
  input  logic [1:0]            rd_field_i,
  output logic                  rd_valid_o,
  output logic [31:0]           rd_data_o
`endif
);

  if (N_LOOPS < 1 || N_LOOPS > MAX_LOOPS) begin : g_bad_cfg
    $error("cve2_hwloop_unit: N_LOOPS out of range");
  end

  logic [31:0]          start_q [N_LOOPS];
  logic [31:0]          end_q   [N_LOOPS];
  logic [CNT_WIDTH-1:0] cnt_q   [N_LOOPS];
  logic [N_LOOPS-1:0]   match;
  logic [N_LOOPS-1:0]   sel;
  logic [N_LOOPS-1:0]   dec;

  for (genvar k = 0; k < N_LOOPS; k++) begin : g_loop
    assign sel[k]           = valid_i && (int'(regid_i) == k);
    assign loop_active_o[k] = (cnt_q[k] != '0);

    cve2_hwloop_entry #(.CNT_WIDTH(CNT_WIDTH)) u_entry (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .we_start_i   (sel[k] && we_i[WE_START]),
      .we_end_i     (sel[k] && we_i[WE_END]),
      .we_cnt_i     (sel[k] && we_i[WE_CNT]),
      .dec_i        (dec[k]),
      .start_data_i (start_data_i),
      .end_data_i   (end_data_i),
      .cnt_data_i   (cnt_data_i),
      .pc_i         (pc_i),
      .start_q      (start_q[k]),
      .end_q        (end_q[k]),
      .cnt_q        (cnt_q[k]),
      .match        (match[k])
    );
  end

  logic                 win_any;
  logic [31:0]          win_start;
  logic [CNT_WIDTH-1:0] win_cnt;

  // Lowest index is the innermost loop and takes priority.
  always_comb begin
    win_any   = 1'b0;
    win_start = '0;
    win_cnt   = '0;
    dec       = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      if (!win_any && match[k]) begin
        win_any   = 1'b1;
        win_start = start_q[k];
        win_cnt   = cnt_q[k];
        dec[k]    = 1'b1;
      end
    end
  end

  assign jump_o        = win_any && (win_cnt > CNT_WIDTH'(1));
  assign exit_o        = win_any && (win_cnt == CNT_WIDTH'(1));
  assign jump_target_o = jump_o ? win_start : 32'h0;

`ifdef CVE2_HWLOOP_READBACK_EN
  logic [31:0] rd_sel;

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      if (int'(rd_regid_i) == k) begin
        case (rd_field_e'(rd_field_i))
          RD_START: rd_sel = start_q[k];
          RD_END:   rd_sel = end_q[k];
          RD_COUNT: rd_sel = 32'(cnt_q[k]);
          default:  rd_sel = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_sel;
    end
  end
`endif

endmodule
